// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: start/stop/lap/clear state machine, BCD mm:ss.cc
// counter with sticky wrap flag, and a registered display that shows live or lap time.
module stopwatch_controller #(
  parameter int MIN_MAX = 59
) (
  input  logic       CLK_50MHz,
  input  logic       reset,
  input  logic       tick_100Hz,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic [1:0] state,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);

  sw_state_t   state_r, state_next_s;
  logic [23:0] cnt_r, cnt_next_s;
  logic [23:0] lap_r, lap_next_s;
  logic [23:0] disp_r, disp_next_s;
  logic        ovf_r, ovf_next_s;
  logic        running_r;
  logic        tick_en_s, lap_load_s, clear_s;
  logic [24:0] inc_s;

  // One-centisecond BCD increment of {mt,mo,st,so,ct,co}; bit 24 flags the wrap to zero.
  function automatic logic [24:0] time_inc(input logic [23:0] t);
    logic [3:0] mt, mo, st, so, ct, co;
    logic       wrap;
    {mt, mo, st, so, ct, co} = t;
    wrap = 1'b0;
    if (co != 4'd9) begin
      co = co + 4'd1;
    end else begin
      co = 4'd0;
      if (ct != 4'd9) begin
        ct = ct + 4'd1;
      end else begin
        ct = 4'd0;
        if (so != 4'd9) begin
          so = so + 4'd1;
        end else begin
          so = 4'd0;
          if (st != 4'd5) begin
            st = st + 4'd1;
          end else begin
            st = 4'd0;
            if ((mt == MAX_T) && (mo == MAX_O)) begin
              mt   = 4'd0;
              mo   = 4'd0;
              wrap = 1'b1;
            end else if (mo != 4'd9) begin
              mo = mo + 4'd1;
            end else begin
              mo = 4'd0;
              mt = mt + 4'd1;
            end
          end
        end
      end
    end
    return {wrap, mt, mo, st, so, ct, co};
  endfunction

  // Button sequencing; start_stop takes priority over lap_clear.
  always_comb begin
    state_next_s = state_r;
    lap_load_s   = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn_start_stop) state_next_s = RUN;
        else                state_next_s = IDLE;
      end
      RUN: begin
        if (btn_start_stop) begin
          state_next_s = PAUSE;
        end else if (btn_lap_clear) begin
          state_next_s = LAP;
          lap_load_s   = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      LAP: begin
        if (btn_start_stop)     state_next_s = PAUSE;
        else if (btn_lap_clear) state_next_s = RUN;
        else                    state_next_s = LAP;
      end
      PAUSE: begin
        if (btn_start_stop) begin
          state_next_s = RUN;
        end else if (btn_lap_clear) begin
          state_next_s = IDLE;
          clear_s      = 1'b1;
        end else begin
          state_next_s = PAUSE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Count, lap capture, overflow and display next values; the lap copy takes the pre-tick count.
  always_comb begin
    tick_en_s   = tick_100Hz && ((state_r == RUN) || (state_r == LAP));
    inc_s       = time_inc(cnt_r);
    cnt_next_s  = cnt_r;
    ovf_next_s  = ovf_r;
    if (clear_s) begin
      cnt_next_s = 24'd0;
      ovf_next_s = 1'b0;
    end else if (tick_en_s) begin
      cnt_next_s = inc_s[23:0];
      ovf_next_s = ovf_r | inc_s[24];
    end else begin
      cnt_next_s = cnt_r;
      ovf_next_s = ovf_r;
    end
    if (lap_load_s) lap_next_s = cnt_r;
    else            lap_next_s = lap_r;
    if (state_next_s == LAP) disp_next_s = lap_next_s;
    else                     disp_next_s = cnt_next_s;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 24'd0;
      lap_r     <= 24'd0;
      disp_r    <= 24'd0;
      ovf_r     <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      lap_r     <= lap_next_s;
      disp_r    <= disp_next_s;
      ovf_r     <= ovf_next_s;
      running_r <= (state_next_s == RUN) || (state_next_s == LAP);
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = disp_r;
  assign state    = state_r;
  assign running  = running_r;
  assign overflow = ovf_r;

endmodule
